ising_anneal_scheduler: RTL and testbench

//  Sequences an ising_model_top instance through a stepped annealing run: drives its temperature
//  and enable, discards burn_in update ticks per step, then accumulates sweeps_per_step energy /
//  |magnetization| samples. Emits one result record per temperature step. Sits between the

---
 rtl/ising_pkg.sv | 17 +
 rtl/ising_step_accumulator.sv | 62 ++++++
 rtl/ising_anneal_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_ising_anneal_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared state encoding and default widths for the Ising annealing scheduler.
package ising_pkg;

    localparam int TEMP_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BURNIN  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_FINISH  = 3'd4
    } anneal_state_e;

endpackage

// File: rtl/ising_step_accumulator.sv
// Per-step accumulator: signed energy sum, |magnetization| sum and sample count.
module ising_step_accumulator
    import ising_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] energy,
    input  logic [DATA_WIDTH-1:0] mag,
    output logic [ACC_WIDTH-1:0]  energy_sum,
    output logic [ACC_WIDTH-1:0]  mag_abs_sum,
    output logic [CNT_WIDTH-1:0]  count
);

    logic [ACC_WIDTH-1:0]  energy_sum_q, energy_sum_d;
    logic [ACC_WIDTH-1:0]  mag_abs_sum_q, mag_abs_sum_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] mag_abs;
    logic [ACC_WIDTH-1:0]  energy_ext;

    // Two's-complement negate in DATA_WIDTH bits; the most negative value maps to
    // 2^(DATA_WIDTH-1) once read as unsigned, which is exactly its magnitude.
    assign mag_abs    = mag[DATA_WIDTH-1] ? (~mag + DATA_WIDTH'(1)) : mag;
    assign energy_ext = {{(ACC_WIDTH-DATA_WIDTH){energy[DATA_WIDTH-1]}}, energy};

    always_comb begin
        energy_sum_d  = energy_sum_q;
        mag_abs_sum_d = mag_abs_sum_q;
        count_d       = count_q;
        if (clear) begin
            energy_sum_d  = '0;
            mag_abs_sum_d = '0;
            count_d       = '0;
        end else if (add_en) begin
            energy_sum_d  = energy_sum_q + energy_ext;
            mag_abs_sum_d = mag_abs_sum_q + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, mag_abs};
            count_d       = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            energy_sum_q  <= '0;
            mag_abs_sum_q <= '0;
            count_q       <= '0;
        end else begin
            energy_sum_q  <= energy_sum_d;
            mag_abs_sum_q <= mag_abs_sum_d;
            count_q       <= count_d;
        end
    end

    assign energy_sum  = energy_sum_q;
    assign mag_abs_sum = mag_abs_sum_q;
    assign count       = count_q;

endmodule

// File: rtl/ising_anneal_scheduler.sv
// Steps an Ising model through a descending temperature schedule, discarding burn-in
// sweeps and reporting one accumulated energy/|magnetization| record per step.
module ising_anneal_scheduler
    import ising_pkg::*;
#(
    parameter int TEMP_WIDTH = TEMP_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TEMP_WIDTH-1:0] t_start,
    input  logic [TEMP_WIDTH-1:0] t_end,
    input  logic [TEMP_WIDTH-1:0] t_step,
    input  logic [CNT_WIDTH-1:0]  burn_in,
    input  logic [CNT_WIDTH-1:0]  sweeps_per_step,
    input  logic                  update_tick,
    input  logic [DATA_WIDTH-1:0] system_energy,
    input  logic [DATA_WIDTH-1:0] system_magnetization,
    output logic [TEMP_WIDTH-1:0] temperature,
    output logic                  model_enable,
    output logic                  busy,
    output logic                  step_valid,
    output logic [TEMP_WIDTH-1:0] step_temp,
    output logic [CNT_WIDTH-1:0]  step_index,
    output logic [ACC_WIDTH-1:0]  energy_sum,
    output logic [ACC_WIDTH-1:0]  mag_abs_sum,
    output logic                  done
);

    anneal_state_e         state_q, state_d;
    logic [TEMP_WIDTH-1:0] temperature_q, temperature_d;
    logic                  model_enable_q, model_enable_d;
    logic [CNT_WIDTH-1:0]  step_idx_q, step_idx_d;
    logic [TEMP_WIDTH-1:0] t_end_q, t_end_d;
    logic [TEMP_WIDTH-1:0] t_step_q, t_step_d;
    logic [CNT_WIDTH-1:0]  burn_in_q, burn_in_d;
    logic [CNT_WIDTH-1:0]  sweeps_q, sweeps_d;
    logic [CNT_WIDTH-1:0]  burn_cnt_q, burn_cnt_d;
    logic [TEMP_WIDTH-1:0] rep_temp_q, rep_temp_d;
    logic [CNT_WIDTH-1:0]  rep_idx_q, rep_idx_d;
    logic [ACC_WIDTH-1:0]  rep_energy_q, rep_energy_d;
    logic [ACC_WIDTH-1:0]  rep_mag_q, rep_mag_d;

    logic                  acc_clear, acc_add;
    logic [ACC_WIDTH-1:0]  acc_energy, acc_mag;
    logic [CNT_WIDTH-1:0]  acc_count;
    logic [CNT_WIDTH:0]    sweeps_eff;
    logic                  last_step;
    logic                  report_fire, finish_fire;

    ising_step_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .add_en      (acc_add),
        .energy      (system_energy),
        .mag         (system_magnetization),
        .energy_sum  (acc_energy),
        .mag_abs_sum (acc_mag),
        .count       (acc_count)
    );

    assign sweeps_eff  = (sweeps_q == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, sweeps_q};
    // Widened compare so t_end + t_step cannot wrap and fake another step.
    assign last_step   = (t_step_q == '0) ||
                         ({1'b0, temperature_q} < ({1'b0, t_end_q} + {1'b0, t_step_q}));
    assign report_fire = (state_q == ST_REPORT) && !abort;
    assign finish_fire = (state_q == ST_FINISH) && !abort;

    always_comb begin
        state_d        = state_q;
        temperature_d  = temperature_q;
        model_enable_d = model_enable_q;
        step_idx_d     = step_idx_q;
        t_end_d        = t_end_q;
        t_step_d       = t_step_q;
        burn_in_d      = burn_in_q;
        sweeps_d       = sweeps_q;
        burn_cnt_d     = burn_cnt_q;
        rep_temp_d     = rep_temp_q;
        rep_idx_d      = rep_idx_q;
        rep_energy_d   = rep_energy_q;
        rep_mag_d      = rep_mag_q;
        acc_clear      = 1'b0;
        acc_add        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    t_end_d        = t_end;
                    t_step_d       = t_step;
                    burn_in_d      = burn_in;
                    sweeps_d       = sweeps_per_step;
                    temperature_d  = t_start;
                    model_enable_d = 1'b1;
                    step_idx_d     = '0;
                    burn_cnt_d     = '0;
                    acc_clear      = 1'b1;
                    state_d        = ST_BURNIN;
                end
            end
            ST_BURNIN: begin
                if (burn_in_q == '0) begin
                    state_d = ST_MEASURE;
                end else if (update_tick) begin
                    if (burn_cnt_q == burn_in_q - CNT_WIDTH'(1)) begin
                        burn_cnt_d = '0;
                        state_d    = ST_MEASURE;
                    end else begin
                        burn_cnt_d = burn_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_MEASURE: begin
                if (update_tick) begin
                    acc_add = 1'b1;
                    if (({1'b0, acc_count} + (CNT_WIDTH+1)'(1)) >= sweeps_eff)
                        state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                rep_temp_d   = temperature_q;
                rep_idx_d    = step_idx_q;
                rep_energy_d = acc_energy;
                rep_mag_d    = acc_mag;
                if (last_step) begin
                    state_d = ST_FINISH;
                end else begin
                    temperature_d = temperature_q - t_step_q;
                    step_idx_d    = step_idx_q + CNT_WIDTH'(1);
                    burn_cnt_d    = '0;
                    acc_clear     = 1'b1;
                    state_d       = ST_BURNIN;
                end
            end
            ST_FINISH: begin
                model_enable_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards the in-flight step; the held record stays at the last reported one.
        if (abort && state_q != ST_IDLE) begin
            state_d        = ST_IDLE;
            model_enable_d = 1'b0;
            temperature_d  = temperature_q;
            step_idx_d     = step_idx_q;
            acc_add        = 1'b0;
            acc_clear      = 1'b0;
            rep_temp_d     = rep_temp_q;
            rep_idx_d      = rep_idx_q;
            rep_energy_d   = rep_energy_q;
            rep_mag_d      = rep_mag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            temperature_q  <= '0;
            model_enable_q <= 1'b0;
            step_idx_q     <= '0;
            t_end_q        <= '0;
            t_step_q       <= '0;
            burn_in_q      <= '0;
            sweeps_q       <= '0;
            burn_cnt_q     <= '0;
            rep_temp_q     <= '0;
            rep_idx_q      <= '0;
            rep_energy_q   <= '0;
            rep_mag_q      <= '0;
        end else begin
            state_q        <= state_d;
            temperature_q  <= temperature_d;
            model_enable_q <= model_enable_d;
            step_idx_q     <= step_idx_d;
            t_end_q        <= t_end_d;
            t_step_q       <= t_step_d;
            burn_in_q      <= burn_in_d;
            sweeps_q       <= sweeps_d;
            burn_cnt_q     <= burn_cnt_d;
            rep_temp_q     <= rep_temp_d;
            rep_idx_q      <= rep_idx_d;
            rep_energy_q   <= rep_energy_d;
            rep_mag_q      <= rep_mag_d;
        end
    end

    // During REPORT the live step is presented directly; afterwards the captured copy holds it.
    assign temperature  = temperature_q;
    assign model_enable = model_enable_q;
    assign busy         = (state_q != ST_IDLE);
    assign step_valid   = report_fire;
    assign done         = finish_fire;
    assign step_temp    = report_fire ? temperature_q : rep_temp_q;
    assign step_index   = report_fire ? step_idx_q    : rep_idx_q;
    assign energy_sum   = report_fire ? acc_energy    : rep_energy_q;
    assign mag_abs_sum  = report_fire ? acc_mag       : rep_mag_q;

endmodule

// File: tb/tb_ising_anneal_scheduler.sv
// Scoreboard bench: expected step records are queued at start and popped on step_valid.
module tb_ising_anneal_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, abort, update_tick;
    logic [7:0]  t_start, t_end, t_step, temperature, step_temp;
    logic [15:0] burn_in, sweeps_per_step, system_energy, system_magnetization, step_index;
    logic        model_enable, busy, step_valid, done;
    logic [31:0] energy_sum, mag_abs_sum;

    typedef struct {
        logic [7:0]  temp;
        logic [15:0] idx;
        logic [31:0] e;
        logic [31:0] m;
    } rec_t;

    rec_t sb[$];
    int   checks = 0, errors = 0;
    int   done_cnt = 0, step_cnt = 0, tick_seen = 0;
    logic tick_en = 1'b0;

    int etbl [15] = '{100, 101, -32, -24, -16, 7, 8, -5, 300, -400, 9, 9, -1000, 2000, -32768};
    int mtbl [15] = '{50, -50, -8, 4, -2, 1, -1, 3, -32768, 100, 5, 5, -7, 32767, -3};

    ising_anneal_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .t_start(t_start), .t_end(t_end), .t_step(t_step),
        .burn_in(burn_in), .sweeps_per_step(sweeps_per_step),
        .update_tick(update_tick), .system_energy(system_energy),
        .system_magnetization(system_magnetization),
        .temperature(temperature), .model_enable(model_enable), .busy(busy),
        .step_valid(step_valid), .step_temp(step_temp), .step_index(step_index),
        .energy_sum(energy_sum), .mag_abs_sum(mag_abs_sum), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Model: ticks arrive in a fixed sequence, each step eats burn_in then sweeps of them.
    task automatic push_run(input int ts, input int te, input int tst, input int b, input int s);
        int temp, seff, t, e, m;
        temp = ts;
        seff = (s == 0) ? 1 : s;
        for (int step = 0; step < 300; step++) begin
            e = 0; m = 0;
            for (int j = 0; j < seff; j++) begin
                t = step * (b + seff) + b + j;
                e += etbl[t % 15];
                m += (mtbl[t % 15] < 0) ? -mtbl[t % 15] : mtbl[t % 15];
            end
            sb.push_back('{temp[7:0], step[15:0], e, m});
            if (tst == 0 || temp < te + tst) break;
            temp -= tst;
        end
    endtask

    task automatic start_run(input int ts, input int te, input int tst, input int b, input int s);
        push_run(ts, te, tst, b, s);
        @(posedge clk); #1;
        t_start = 8'(ts); t_end = 8'(te); t_step = 8'(tst);
        burn_in = 16'(b); sweeps_per_step = 16'(s);
        start = 1'b1; tick_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == d0; i++) begin
            @(negedge clk); #1;
        end
        chk(tag, done_cnt - d0, 1);
        tick_en = 1'b0;
    endtask

    // Tick source: one update_tick every 4 cycles while a run is active.
    initial begin
        int idx, cnt;
        update_tick = 1'b0; system_energy = '0; system_magnetization = '0;
        forever begin
            @(posedge clk); #1;
            if (!tick_en) begin
                idx = 0; cnt = 0; update_tick = 1'b0;
            end else begin
                cnt++;
                if (cnt == 4) begin
                    cnt = 0;
                    update_tick = 1'b1;
                    system_energy = 16'(etbl[idx % 15]);
                    system_magnetization = 16'(mtbl[idx % 15]);
                    idx++;
                end else begin
                    update_tick = 1'b0;
                end
            end
        end
    end

    // Monitor: pop and compare on every step_valid.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (update_tick) tick_seen++;
            if (done) done_cnt++;
            if (step_valid) begin
                step_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_step", 32'd1, 32'd0);
                end else begin
                    r = sb.pop_front();
                    chk("step_temp", {24'd0, step_temp}, {24'd0, r.temp});
                    chk("step_index", {16'd0, step_index}, {16'd0, r.idx});
                    chk("energy_sum", energy_sum, r.e);
                    chk("mag_abs_sum", mag_abs_sum, r.m);
                end
            end
        end
    end

    initial begin
        int s0, t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        t_start = '0; t_end = '0; t_step = '0; burn_in = '0; sweeps_per_step = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_enable", {31'd0, model_enable}, 0);
        chk("rst_temp", {24'd0, temperature}, 0);
        chk("rst_valid_done", {30'd0, step_valid, done}, 0);
        chk("rst_sums", energy_sum | mag_abs_sum, 0);

        // Run A: three steps; a second start with new config mid-run must be ignored.
        s0 = step_cnt;
        start_run('h20, 'h10, 'h08, 2, 3);
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("enable_after_start", {31'd0, model_enable}, 1);
        chk("temp_after_start", {24'd0, temperature}, 'h20);
        for (int i = 0; i < 200 && step_cnt == s0; i++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; t_end = 8'h00; t_step = 8'h01; burn_in = 16'd0; sweeps_per_step = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("done_a", 400);
        chk("steps_a", step_cnt - s0, 3);
        chk("sb_left_a", sb.size(), 0);
        @(negedge clk);
        chk("enable_off_a", {31'd0, model_enable}, 0);
        chk("busy_off_a", {31'd0, busy}, 0);
        chk("temp_hold_a", {24'd0, temperature}, 'h10);

        // Degenerate config: one sample, one step.
        s0 = step_cnt;
        start_run('h33, 'h40, 'h00, 0, 0);
        wait_done("done_b", 100);
        chk("steps_b", step_cnt - s0, 1);

        // t_end above what t_step can reach: single step, no underflow.
        s0 = step_cnt;
        start_run('h05, 'h00, 'h08, 1, 2);
        wait_done("done_c", 100);
        chk("steps_c", step_cnt - s0, 1);
        chk("temp_hold_c", {24'd0, temperature}, 'h05);

        // Abort in MEASURE of step 1.
        s0 = step_cnt;
        start_run('h20, 'h10, 'h08, 2, 3);
        for (int i = 0; i < 200 && step_cnt == s0; i++) @(negedge clk);
        chk("abort_step0_seen", step_cnt - s0, 1);
        t0 = tick_seen;
        for (int i = 0; i < 100 && tick_seen - t0 < 3; i++) @(negedge clk);
        t0 = done_cnt;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; tick_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_enable", {31'd0, model_enable}, 0);
        chk("abort_hold_temp", {24'd0, step_temp}, 'h20);
        chk("abort_hold_idx", {16'd0, step_index}, 0);
        chk("abort_hold_energy", energy_sum, 32'(-72));
        chk("abort_hold_mag", mag_abs_sum, 14);
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - t0, 0);
        chk("abort_no_more_steps", step_cnt - s0, 1);
        sb.delete();

        // start+abort together in IDLE.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", {30'd0, busy, model_enable}, 0);

        // Reset mid-run clears everything without pulses.
        start_run('h20, 'h10, 'h08, 2, 3);
        repeat (20) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1; tick_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_en", {30'd0, busy, model_enable}, 0);
        chk("midrst_pulses", {30'd0, step_valid, done}, 0);
        chk("midrst_temp", {16'd0, temperature, step_temp}, 0);
        chk("midrst_idx", {16'd0, step_index}, 0);
        chk("midrst_sums", energy_sum | mag_abs_sum, 0);
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
